// File: rtl/lif_neuron_array_pkg.sv
// Shared definitions for the LIF neuron array:
//   - cfg_sel encoding for the configuration write port
//   - default reset values of the runtime configuration registers
//   - width of the leak-shift configuration field
package snn_pkg;

  typedef enum logic [1:0] {
    CFG_THRESH = 2'd0,
    CFG_LEAK   = 2'd1,
    CFG_REF    = 2'd2,
    CFG_NONE   = 2'd3
  } cfg_sel_e;

  localparam int unsigned DEF_THRESH_INIT = 200;
  localparam int unsigned DEF_LEAK_INIT   = 3;
  localparam int unsigned DEF_REF_INIT    = 2;

  localparam int unsigned LEAK_W = 4;

endpackage

// File: rtl/lif_neuron_array_if.sv
// Pin-level bundle of the LIF neuron array.
//   master : drives input currents, config write port and debug select;
//            receives spike vector, any_spike, tick and debug membrane.
//   slave  : the neuron array side.
interface lif_neuron_array_if #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned W_IN      = 8,
  parameter int unsigned W_MEM     = 12,
  parameter int unsigned W_SEL     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);

  logic [N_NEURONS*W_IN-1:0] cur_in;
  logic                      cfg_we;
  logic [1:0]                cfg_sel;
  logic [W_MEM-1:0]          cfg_data;
  logic [N_NEURONS-1:0]      spike;
  logic                      any_spike;
  logic                      tick;
  logic [W_SEL-1:0]          mem_sel;
  logic [W_MEM-1:0]          mem_dbg;

  modport master (
    output cur_in, cfg_we, cfg_sel, cfg_data, mem_sel,
    input  spike, any_spike, tick, mem_dbg
  );

  modport slave (
    input  cur_in, cfg_we, cfg_sel, cfg_data, mem_sel,
    output spike, any_spike, tick, mem_dbg
  );

endinterface

// File: rtl/lif_neuron_array_neuron.sv
// One leaky-integrate-and-fire channel.
//   clk, reset  : clock, synchronous active-high reset
//   tick_en     : time-step strobe; state only changes when high
//   cur         : unsigned input current
//   threshold   : spike threshold
//   leak_shift  : leak = v >> leak_shift (0 disables leak)
//   refractory  : ticks held at 0 after a spike
//   mem         : membrane potential register
//   spike       : one-cycle spike pulse, registered
module lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_MEM = 12,
  parameter int unsigned W_REF = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic [W_IN-1:0]   cur,
  input  logic [W_MEM-1:0]  threshold,
  input  logic [LEAK_W-1:0] leak_shift,
  input  logic [W_REF-1:0]  refractory,
  output logic [W_MEM-1:0]  mem,
  output logic              spike
);

  logic [W_REF-1:0] ref_cnt;
  logic [W_MEM-1:0] leak;
  logic [W_MEM:0]   v_sum;
  logic [W_MEM-1:0] v_sat;

  // v - leak never underflows (leak <= v), so one extra bit covers + cur.
  always_comb begin
    leak  = (leak_shift == '0) ? '0 : (mem >> leak_shift);
    v_sum = {1'b0, mem} - {1'b0, leak} + {{(W_MEM + 1 - W_IN){1'b0}}, cur};
    v_sat = v_sum[W_MEM] ? '1 : v_sum[W_MEM-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem     <= '0;
      ref_cnt <= '0;
      spike   <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (tick_en) begin
        if (ref_cnt != '0) begin
          ref_cnt <= ref_cnt - 1'b1;
          mem     <= '0;
        end else if (v_sat >= threshold) begin
          spike   <= 1'b1;
          mem     <= '0;
          ref_cnt <= refractory;
        end else begin
          mem <= v_sat;
        end
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_NEURONS LIF neurons with shared runtime configuration.
//   clk, reset : clock, synchronous active-high reset
//   bus.cur_in : per-channel input currents, channel i at [i*W_IN +: W_IN]
//   bus.cfg_*  : config write port (threshold / leak shift / refractory)
//   bus.spike  : per-channel spike pulses, bus.any_spike their OR
//   bus.tick   : registered time-step strobe, aligned with spike
//   bus.mem_sel/mem_dbg : debug read of one channel's membrane
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS   = 4,
  parameter int unsigned W_IN        = 8,
  parameter int unsigned W_MEM       = 12,
  parameter int unsigned W_REF       = 4,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned THRESH_INIT = DEF_THRESH_INIT,
  parameter int unsigned LEAK_INIT   = DEF_LEAK_INIT,
  parameter int unsigned REF_INIT    = DEF_REF_INIT
) (
  input logic              clk,
  input logic              reset,
  lif_neuron_array_if.slave bus
);

  localparam int unsigned W_CNT = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned W_SEL = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic [W_CNT-1:0]     pre_cnt;
  logic                 tick_en;
  logic                 tick_q;
  logic [W_MEM-1:0]     threshold;
  logic [LEAK_W-1:0]    leak_shift;
  logic [W_REF-1:0]     refractory;
  logic [N_NEURONS-1:0] spike_vec;
  logic [W_MEM-1:0]     mem [N_NEURONS];
  logic [W_MEM-1:0]     mem_dbg_c;

  assign tick_en = (pre_cnt == W_CNT'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= tick_en ? '0 : pre_cnt + 1'b1;
      tick_q  <= tick_en;
    end
  end

  // Neurons sample the pre-edge register values, so a write landing on a
  // tick edge only takes effect from the following tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      threshold  <= W_MEM'(THRESH_INIT);
      leak_shift <= LEAK_W'(LEAK_INIT);
      refractory <= W_REF'(REF_INIT);
    end else if (bus.cfg_we) begin
      case (cfg_sel_e'(bus.cfg_sel))
        CFG_THRESH: threshold  <= bus.cfg_data;
        CFG_LEAK:   leak_shift <= bus.cfg_data[LEAK_W-1:0];
        CFG_REF:    refractory <= bus.cfg_data[W_REF-1:0];
        default:    ;
      endcase
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    lif_neuron #(
      .W_IN  (W_IN),
      .W_MEM (W_MEM),
      .W_REF (W_REF)
    ) u_neuron (
      .clk        (clk),
      .reset      (reset),
      .tick_en    (tick_en),
      .cur        (bus.cur_in[i*W_IN +: W_IN]),
      .threshold  (threshold),
      .leak_shift (leak_shift),
      .refractory (refractory),
      .mem        (mem[i]),
      .spike      (spike_vec[i])
    );
  end

  // Selects with no matching channel fall through to 0.
  always_comb begin
    mem_dbg_c = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (bus.mem_sel == W_SEL'(i)) mem_dbg_c = mem[i];
    end
  end

  assign bus.spike     = spike_vec;
  assign bus.any_spike = |spike_vec;
  assign bus.tick      = tick_q;
  assign bus.mem_dbg   = mem_dbg_c;

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;

  localparam int NN = 4;
  localparam int WI = 8;
  localparam int WM = 12;
  localparam int TD_A = 1;
  localparam int MAXV = 4095;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  always #5 clk = ~clk;

  lif_neuron_array_if #(.N_NEURONS(NN), .W_IN(WI), .W_MEM(WM)) ifa ();
  lif_neuron_array_if #(.N_NEURONS(NN), .W_IN(WI), .W_MEM(WM)) ifb ();

  lif_neuron_array #(
    .N_NEURONS(NN), .W_IN(WI), .W_MEM(WM), .W_REF(4), .TICK_DIV(TD_A),
    .THRESH_INIT(200), .LEAK_INIT(3), .REF_INIT(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.slave)
  );

  lif_neuron_array #(
    .N_NEURONS(NN), .W_IN(WI), .W_MEM(WM), .W_REF(4), .TICK_DIV(4),
    .THRESH_INIT(200), .LEAK_INIT(3), .REF_INIT(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.slave)
  );

  typedef struct packed {
    logic [NN-1:0]    spike;
    logic             any;
    logic             tick;
    logic [NN*WM-1:0] mem;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state for dut_a
  int m_v[NN];
  int m_ref[NN];
  int m_thr, m_leak, m_refp, m_cnt;
  int obs_v[NN];
  logic [NN-1:0] obs_spike;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Predict the next edge from the currently driven inputs, push, clock,
  // then pop and compare every observable output of dut_a.
  task automatic run_cycle();
    exp_t e;
    exp_t got;
    int   s, lk, cur;
    bit   ten;
    e   = '0;
    ten = (m_cnt == TD_A - 1);
    if (reset_a) begin
      for (int c = 0; c < NN; c++) begin
        m_v[c] = 0;
        m_ref[c] = 0;
      end
      m_thr = 200; m_leak = 3; m_refp = 2; m_cnt = 0;
      e.tick = 1'b0;
    end else begin
      if (ten) begin
        for (int c = 0; c < NN; c++) begin
          cur = int'(ifa.cur_in[c*WI +: WI]);
          if (m_ref[c] > 0) begin
            m_ref[c] = m_ref[c] - 1;
            m_v[c] = 0;
          end else begin
            lk = (m_leak == 0) ? 0 : (m_v[c] >> m_leak);
            s  = m_v[c] - lk + cur;
            if (s > MAXV) s = MAXV;
            if (s >= m_thr) begin
              e.spike[c] = 1'b1;
              m_v[c] = 0;
              m_ref[c] = m_refp;
            end else begin
              m_v[c] = s;
            end
          end
        end
      end
      if (ifa.cfg_we) begin
        case (ifa.cfg_sel)
          2'd0: m_thr  = int'(ifa.cfg_data);
          2'd1: m_leak = int'(ifa.cfg_data) & 15;
          2'd2: m_refp = int'(ifa.cfg_data) & 15;
          default: ;
        endcase
      end
      m_cnt  = ten ? 0 : m_cnt + 1;
      e.tick = ten;
    end
    e.any = |e.spike;
    for (int c = 0; c < NN; c++) e.mem[c*WM +: WM] = WM'(m_v[c]);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    obs_spike = ifa.spike;
    check("sb_spike", 32'(ifa.spike), 32'(got.spike));
    check("sb_any", 32'(ifa.any_spike), 32'(got.any));
    check("sb_tick", 32'(ifa.tick), 32'(got.tick));
    for (int c = 0; c < NN; c++) begin
      ifa.mem_sel = 2'(c);
      #1;
      obs_v[c] = int'(ifa.mem_dbg);
      check($sformatf("sb_mem%0d", c), 32'(ifa.mem_dbg), 32'(got.mem[c*WM +: WM]));
    end
    ifa.mem_sel = '0;
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    ifa.cur_in = {WI'(c3), WI'(c2), WI'(c1), WI'(c0)};
  endtask

  task automatic reset_a_cycles(input int n);
    reset_a = 1'b1;
    ifa.cfg_we = 1'b0;
    set_cur(0, 0, 0, 0);
    repeat (n) run_cycle();
    reset_a = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int data);
    ifa.cfg_we   = 1'b1;
    ifa.cfg_sel  = 2'(sel);
    ifa.cfg_data = WM'(data);
    run_cycle();
    ifa.cfg_we   = 1'b0;
  endtask

  // membrane of ch0 and spike of ch0 after ticks 1..9 with defaults, cur0=50
  int t1_v[9]  = '{50, 94, 133, 167, 197, 0, 0, 0, 50};
  int t1_sp[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

  task automatic default_sequence(input string pfx);
    set_cur(50, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      run_cycle();
      check($sformatf("%s_v0_t%0d", pfx, k + 1), 32'(obs_v[0]), 32'(t1_v[k]));
      check($sformatf("%s_sp_t%0d", pfx, k + 1), 32'(obs_spike), 32'(t1_sp[k]));
    end
  endtask

  initial begin
    ifa.cfg_we = 1'b0; ifa.cfg_sel = '0; ifa.cfg_data = '0; ifa.mem_sel = '0;
    ifa.cur_in = '0;
    ifb.cfg_we = 1'b0; ifb.cfg_sel = '0; ifb.cfg_data = '0; ifb.mem_sel = '0;
    ifb.cur_in = '0;
    m_cnt = 0; m_thr = 200; m_leak = 3; m_refp = 2;
    for (int c = 0; c < NN; c++) begin
      m_v[c] = 0;
      m_ref[c] = 0;
    end

    // reset state
    reset_a_cycles(2);
    check("rst_spike", 32'(ifa.spike), 32'd0);
    check("rst_tick", 32'(ifa.tick), 32'd0);
    check("rst_any", 32'(ifa.any_spike), 32'd0);

    // 1: defaults, cur0=50
    default_sequence("t1");

    // 2: saturation at threshold 4095 with no leak
    reset_a_cycles(1);
    cfg_write(0, 4095);
    cfg_write(1, 0);
    set_cur(255, 0, 0, 0);
    repeat (16) run_cycle();
    check("t2_v0_4080", 32'(obs_v[0]), 32'd4080);
    check("t2_nospike", 32'(obs_spike), 32'd0);
    run_cycle();
    check("t2_sat_spike", 32'(obs_spike), 32'd1);
    check("t2_v0_clear", 32'(obs_v[0]), 32'd0);

    // 3: threshold 0, refractory 2 -> all channels fire every third tick
    reset_a_cycles(1);
    cfg_write(0, 0);
    for (int k = 1; k <= 9; k++) begin
      run_cycle();
      check($sformatf("t3_spike_t%0d", k), 32'(ifa.spike),
            (k % 3 == 1) ? 32'hF : 32'h0);
      check($sformatf("t3_any_t%0d", k), 32'(ifa.any_spike),
            (k % 3 == 1) ? 32'd1 : 32'd0);
    end

    // 5: threshold write coincident with a tick uses the old threshold
    reset_a_cycles(1);
    set_cur(100, 0, 0, 0);
    ifa.cfg_we = 1'b1; ifa.cfg_sel = 2'd0; ifa.cfg_data = 12'd50;
    run_cycle();
    ifa.cfg_we = 1'b0;
    check("t5_old_thr_sp", 32'(obs_spike), 32'd0);
    check("t5_old_thr_v0", 32'(obs_v[0]), 32'd100);
    run_cycle();
    check("t5_new_thr_sp", 32'(obs_spike), 32'd1);
    check("t5_new_thr_v0", 32'(obs_v[0]), 32'd0);

    // 6: mid-run reset with non-default config and ch1 refractory
    reset_a_cycles(1);
    cfg_write(2, 5);
    set_cur(50, 250, 0, 0);
    repeat (4) run_cycle();
    check("t6_pre_v0", 32'(obs_v[0]), 32'd167);
    check("t6_pre_v1", 32'(obs_v[1]), 32'd0);
    reset_a = 1'b1;
    run_cycle();
    reset_a = 1'b0;
    check("t6_rst_v0", 32'(obs_v[0]), 32'd0);
    check("t6_rst_spike", 32'(obs_spike), 32'd0);
    check("t6_rst_tick", 32'(ifa.tick), 32'd0);
    default_sequence("t6");

    // 4: TICK_DIV=4 instance, cur0=60, defaults
    ifb.cur_in = {WI'(0), WI'(0), WI'(0), WI'(60)};
    ifb.mem_sel = '0;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      int ev;
      @(posedge clk);
      #1;
      ev = (k < 4) ? 0 : (k < 8) ? 60 : (k < 12) ? 113 : (k < 16) ? 159 : 0;
      check($sformatf("t4_tick_c%0d", k), 32'(ifb.tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t4_spike_c%0d", k), 32'(ifb.spike), (k == 16) ? 32'd1 : 32'd0);
      check($sformatf("t4_any_c%0d", k), 32'(ifb.any_spike), (k == 16) ? 32'd1 : 32'd0);
      check($sformatf("t4_v0_c%0d", k), 32'(ifb.mem_dbg), 32'(ev));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Parametrised array of N leaky-integrate-and-fire neurons with shared runtime-configurable threshold, leak and refractory period.
- Membranes update once per time-step tick from an internal prescaler.
- Sits between the chip input pins (per-channel input currents) and the output pins (spike vector).
- Successor to the single fixed neuron; adds channel count, saturating arithmetic, refractory handling, a config write port and tick division.

Parameters:
- N_NEURONS, 4, number of neuron channels.
- W_IN, 8, width of each input current (unsigned).
- W_MEM, 12, membrane potential and threshold width (unsigned).
- W_REF, 4, refractory counter width.
- TICK_DIV, 1, clock cycles per time-step (>=1).
- THRESH_INIT, 200, reset value of threshold.
- LEAK_INIT, 3, reset value of leak shift.
- REF_INIT, 2, reset value of refractory period (ticks).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cur_in  in  N_NEURONS*W_IN  input currents; channel i at [i*W_IN +: W_IN].
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  0=threshold, 1=leak shift (low 4 bits used), 2=refractory (low W_REF bits used), 3=ignored.
- cfg_data  in  W_MEM  config write data.
- spike  out  N_NEURONS  per-channel spike pulse.
- any_spike  out  1  OR of spike.
- tick  out  1  time-step strobe, registered.
- mem_sel  in  clog2(N_NEURONS)  debug channel select.
- mem_dbg  out  W_MEM  membrane of channel mem_sel (combinational mux of registers).

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset state: all membranes 0, refractory counters 0, spike 0, any_spike 0, tick 0, prescaler 0, config regs = *_INIT.
- Prescaler counts 0..TICK_DIV-1. Internal tick_en is high when count==TICK_DIV-1, then the count wraps to 0.
- TICK_DIV=1 means tick_en every cycle.
- Output tick is tick_en registered, aligned with spike.
- On each tick_en edge, every channel evaluates independently:
  - Refractory (ref_cnt>0): ref_cnt-=1; v stays 0; input ignored; no spike.
  - Else: leak = (leak_shift==0) ? 0 : v>>leak_shift; v_sum = v - leak + cur.
  - Computed in W_MEM+1 bits, saturated to 2^W_MEM-1.
  - If v_sum >= threshold: spike[i]=1 for exactly one cycle; v=0; ref_cnt=refractory.
  - Otherwise v=v_sum.
- threshold==0: every non-refractory tick spikes. refractory==0: no refractory ticks.
- spike and any_spike are 0 in all cycles without tick_en.
- Config writes land at the clock edge. A write coincident with tick_en does not affect that tick's evaluation; the old value is used and the new value applies from the next tick.
- Config writes never alter membranes or in-flight refractory counts.
- Reset mid-operation clears everything in the next edge, including a pending spike. The prescaler restarts, so the first tick comes TICK_DIV cycles after reset deasserts.
- mem_sel out of range: mem_dbg = 0.

Decomposition:
- Package snn_pkg holds:
  - cfg_sel encoding constants CFG_THRESH=0, CFG_LEAK=1, CFG_REF=2.
  - Default INIT constants.
  - Leak shift width constant (4).
- Sub-module lif_neuron holds one channel: membrane register, refractory counter, saturating update, spike flop.
  - Inputs: clk, reset, tick_en, cur, threshold, leak_shift, refractory.
  - Instantiated N_NEURONS times via generate.
- Top level holds the prescaler, config registers, tick register, any_spike OR and debug mux.

Test Plan:
1. Defaults (thr 200, leak 3, ref 2, TICK_DIV=1), cur0=50, others 0 -> v0 follows 50, 94, 133, 167, 197; spike[0] on tick 6 (v_sum 223), then v0=0 on ticks 7-8; v0=50 on tick 9; spike[1..3] stay 0.
2. Write thr=4095, leak=0; cur0=255 -> v0=4080 after tick 16; tick 17 saturates to 4095, spike[0]=1, v0=0.
3. Write thr=0, ref=2, cur=0 all channels -> spike=4'hF and any_spike=1 on ticks 1, 4, 7; 0 otherwise.
4. TICK_DIV=4 build -> tick high every 4th cycle, first 4 cycles after reset release; spike only in tick cycles; membranes constant between ticks.
5. cfg_we thr=50 in same cycle as tick with v_sum=100, old thr 200 -> no spike that tick; next tick (v_sum>=50) spikes.
6. Assert reset for 1 cycle while v0=167 and ref_cnt active on ch1 -> next cycle all v=0, spike=0, config back to 200/3/2, tick resumes after TICK_DIV cycles.
